// File: rtl/fallthrough_small_fifo_pkg.sv
// Purpose: shared sizing helpers for the data-path blocks (ceil-log2 for pointer/address widths).
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package fallthrough_small_fifo_pkg;

   // Ceil-log2, never below 1, so that a 1-entry memory still gets a legal 1-bit address.
   function automatic int log2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo_fifo_mem.sv
// Purpose: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller qualifies we.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_mem
   import fallthrough_small_fifo_pkg::*;
#(
   parameter int WIDTH  = 72,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = log2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset on storage: contents are don't-care until written, and the read
   // must stay asynchronous so the head word falls through without a bubble.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fallthrough_small_fifo.sv
// Purpose: first-word-fall-through FIFO; head word always on dout while not empty.
// Latency: write-to-dout 1 cycle; pop-to-next-word 0 bubbles; flags one edge after cause.
// Backpressure: writes while full are dropped; upstream throttles on nearly_full, reads while empty ignored.
// Ports: clk, reset (async active-low), din/wr_en, rd_en/dout, full/nearly_full/prog_full/empty.
module fallthrough_small_fifo
   import fallthrough_small_fifo_pkg::*;
#(
   parameter int WIDTH               = 72,
   parameter int MAX_DEPTH_BITS      = 3,
   parameter int PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             prog_full,
   output logic             empty
);

   localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
   localparam int CNT_W = MAX_DEPTH_BITS + 1;

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_NEARLY = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_PROG   = CNT_W'(PROG_FULL_THRESHOLD);

   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]          count;
   logic                      wr_ok;
   logic                      rd_ok;

   // Both qualifiers look at the pre-edge flags, so a write while full is
   // dropped even when a pop happens on the same edge.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (dout)
   );

   // Pointers wrap naturally: DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
         if (rd_ok) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Flags come only from the registered count, never from wr_en/rd_en.
   assign empty       = (count == '0);
   assign full        = (count == CNT_FULL);
   assign nearly_full = (count >= CNT_NEARLY);
   assign prog_full   = (count >= CNT_PROG);

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
module tb_fallthrough_small_fifo;

   localparam int W     = 72;
   localparam int MDB   = 3;
   localparam int DEPTH = 8;
   localparam int PFT   = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] dout;
   logic         full;
   logic         nearly_full;
   logic         prog_full;
   logic         empty;

   logic [W-1:0] q [$];
   int checks = 0;
   int errors = 0;

   fallthrough_small_fifo #(
      .WIDTH               (W),
      .MAX_DEPTH_BITS      (MDB),
      .PROG_FULL_THRESHOLD (PFT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .nearly_full (nearly_full),
      .prog_full   (prog_full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Flags and head word derived from the reference queue's occupancy.
   task automatic check_state(input string tag);
      int n;
      n = q.size();
      check({tag, ".empty"},       W'(empty),       W'(n == 0));
      check({tag, ".full"},        W'(full),        W'(n == DEPTH));
      check({tag, ".nearly_full"}, W'(nearly_full), W'(n >= DEPTH - 1));
      check({tag, ".prog_full"},   W'(prog_full),   W'(n >= PFT));
      if (n != 0) check({tag, ".dout"}, dout, q[0]);
   endtask

   // One clock: drive inputs, update the model from pre-edge occupancy, check after the edge.
   task automatic cycle(input string tag, input logic we, input logic re, input logic [W-1:0] d);
      int n;
      wr_en = we;
      rd_en = re;
      din   = d;
      @(posedge clk);
      n = q.size();
      if (re && n != 0) void'(q.pop_front());
      if (we && n != DEPTH) q.push_back(d);
      #1;
      check_state(tag);
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      reset = 1'b0;
      q.delete();
      #1;
      check_state({tag, ".async"});
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_state({tag, ".rel"});
   endtask

   initial begin
      logic [W-1:0] d;
      reset = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      #1;
      check_state("t1.rst");
      @(negedge clk);
      reset = 1'b1;
      #1;

      // 1: idle after reset
      for (int i = 0; i < 10; i++) cycle("t1.idle", 1'b0, 1'b0, '0);

      // 2: single write falls through and holds without rd_en
      cycle("t2.wr", 1'b1, 1'b0, 72'h00_0000000000000001);
      check("t2.dout", dout, 72'h1);
      check("t2.empty", W'(empty), W'(0));
      for (int i = 0; i < 5; i++) begin
         cycle("t2.hold", 1'b0, 1'b0, '0);
         check("t2.dout_hold", dout, 72'h1);
      end
      cycle("t2.pop", 1'b0, 1'b1, '0);

      // 3: fill to full, drop a 9th write, drain in order
      for (int i = 1; i <= 8; i++) begin
         cycle("t3.fill", 1'b1, 1'b0, W'(i));
         check("t3.prog_full",   W'(prog_full),   W'(i >= 6));
         check("t3.nearly_full", W'(nearly_full), W'(i >= 7));
         check("t3.full",        W'(full),        W'(i >= 8));
      end
      cycle("t3.drop", 1'b1, 1'b0, 72'hFF);
      for (int i = 1; i <= 8; i++) begin
         check("t3.order", dout, W'(i));
         cycle("t3.drain", 1'b0, 1'b1, '0);
      end
      check("t3.empty", W'(empty), W'(1));

      // 4: streaming with one word resident, pointers wrap several times
      cycle("t4.seed", 1'b1, 1'b0, 72'd100);
      for (int i = 0; i < 20; i++) begin
         d = W'(200 + i);
         cycle("t4.stream", 1'b1, 1'b1, d);
         check("t4.follow", dout, d);
         check("t4.one", W'(empty | full | nearly_full), W'(0));
      end
      cycle("t4.pop", 1'b0, 1'b1, '0);

      // 5: write+read while full drops the write; read while empty ignored
      for (int i = 1; i <= 8; i++) cycle("t5.fill", 1'b1, 1'b0, W'(16 + i));
      cycle("t5.wrrd_full", 1'b1, 1'b1, 72'hAA);
      check("t5.full_after", W'(full), W'(0));
      check("t5.nf_after",   W'(nearly_full), W'(1));
      for (int i = 0; i < 7; i++) begin
         check("t5.noaa", dout, W'(18 + i));
         cycle("t5.drain", 1'b0, 1'b1, '0);
      end
      for (int i = 0; i < 3; i++) cycle("t5.under", 1'b0, 1'b1, '0);
      cycle("t5.wr", 1'b1, 1'b0, 72'h55);
      check("t5.after_under", dout, 72'h55);
      cycle("t5.pop", 1'b0, 1'b1, '0);

      // 1b: reset mid-traffic with 5 words stored
      for (int i = 0; i < 5; i++) cycle("t1b.fill", 1'b1, 1'b0, W'(32 + i));
      pulse_reset("t1b.reset");
      cycle("t1b.wr", 1'b1, 1'b0, 72'h77);
      check("t1b.dout", dout, 72'h77);

      // random traffic with varying bias toward fill/drain
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 300) % 3;
         d = {$urandom, $urandom, $urandom};
         cycle("rnd",
               ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2))),
               ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2))),
               d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fallthrough_small_fifo.md
# fallthrough_small_fifo

A small first-word-fall-through (FWFT) FIFO that buffers one pipeline word per entry. It serves as the input buffer of user data-path modules, where each 72-bit entry is the {ctrl, data} word. The head word is always presented on `dout` while the FIFO is non-empty, so a consumer can inspect a word before popping it. The upstream ready signal is driven as `!nearly_full`, which leaves one cycle of slack for a write already in flight.

## Interface
Parameters:
- `WIDTH`, default 72: entry width in bits (CTRL_WIDTH+DATA_WIDTH).
- `MAX_DEPTH_BITS`, default 3: DEPTH = 2**MAX_DEPTH_BITS entries.
- `PROG_FULL_THRESHOLD`, default DEPTH-1: occupancy at which `prog_full` asserts.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `din`  in  WIDTH  write data.
- `wr_en`  in  1  write strobe.
- `rd_en`  in  1  pop strobe; acknowledges the word currently on `dout`.
- `dout`  out  WIDTH  head word; valid whenever `empty`=0.
- `full`  out  1  count == DEPTH.
- `nearly_full`  out  1  count >= DEPTH-1.
- `prog_full`  out  1  count >= PROG_FULL_THRESHOLD.
- `empty`  out  1  count == 0.

## Operation
- Storage is a circular buffer of DEPTH entries with MAX_DEPTH_BITS-bit write and read pointers that wrap naturally modulo DEPTH.
- An occupancy counter `count` runs from 0 to DEPTH and is MAX_DEPTH_BITS+1 bits wide.
- Write: when `wr_en`=1 and `full`=0 at a clock edge, store `din` at the write pointer, then increment the write pointer.
  - When `wr_en`=1 and `full`=1, drop the write. Contents, pointers and count do not change.
  - A write while full is dropped even if `rd_en` is asserted in the same cycle, because `full` is judged on the pre-edge value.
- Read: when `rd_en`=1 and `empty`=0, pop the head and increment the read pointer.
  - `rd_en` while empty is ignored.
- Simultaneous valid read and write: count is unchanged and both pointers advance.
- Simultaneous read and write when empty: the write is accepted, the read is ignored, and count becomes 1.
- `dout` is a combinational read of the entry at the read pointer. When `empty`=1, `dout` is don't-care.
- All flags decode combinationally from the registered `count`. The flags are mutually consistent in every cycle.
- Reset (asynchronous assert, synchronous release is acceptable) forces:
  - pointers = 0 and count = 0;
  - `empty`=1, `full`=0, `nearly_full`=0, `prog_full`=0;
  - storage is not cleared.
- A reset asserted mid-operation discards all stored words immediately.

## Timing
- Write-to-output latency is 1 cycle. Write a word at edge n into an empty FIFO: after edge n, `empty`=0 and `dout`=that word.
- Read-to-next-word latency is 0 bubbles. After a popping edge, `dout` shows the next word in the same cycle when count > 1 pre-pop.
- Flags update one edge after the causing write or read. No flag depends combinationally on `wr_en` or `rd_en`.
- Throughput is one write and one read per cycle, sustained.
- No valid/ready handshake exists beyond the flags. Upstream must stop writing on `nearly_full`, and downstream must not rely on `rd_en` while `empty`.

## Structure
- A shared package holds the `log2` / ceil-log2 function used by every data-path block to size `MAX_DEPTH_BITS`-derived widths.
  - No block-specific typedefs go in the package.
- One sub-module, `fifo_mem`: a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
- The top level holds the pointers, the counter and the flag decode.
- Synthesis target is flops/LUT-RAM; block RAM is not used, since a registered read would break fall-through.

## Test plan
Each scenario uses WIDTH=72, MAX_DEPTH_BITS=3 (DEPTH=8) and PROG_FULL_THRESHOLD=6.
1. Reset then idle → `empty`=1, `full`=`nearly_full`=`prog_full`=0 for 10 cycles. Pulse `reset` low mid-traffic with 5 words stored → `empty`=1 on the next sampled cycle, count 0.
2. Write 0x00_0000000000000001 into an empty FIFO with `rd_en`=0 → the next cycle has `empty`=0 and `dout`=0x...01. Hold for 5 cycles and `dout` is unchanged (no pop without `rd_en`).
3. Write 8 words 0x01..0x08 back-to-back:
   - `prog_full` rises after the 6th write and `nearly_full` after the 7th;
   - `full` rises after the 8th;
   - a 9th write of 0xFF is dropped;
   - popping 8 times yields 0x01..0x08 in order, then `empty`=1.
4. Continuous write+read every cycle for 20 cycles, starting with 1 word stored → count stays 1 and `dout` follows each written word one cycle later. Pointers wrap past 7→0 with no data loss.
5. While full, assert `wr_en`=`rd_en`=1 with `din`=0xAA → the head is popped, 0xAA is not stored, and count becomes 7. With `rd_en`=1 on an empty FIFO, `empty` stays 1 and no underflow occurs (a later single write reads back correctly).
